// File: rtl/io_thread_request_queue_if.sv
// io_thread_request_queue_if: packet types and the interconnect channel of the per-core IO request queue.
// master = queue side, slave = interconnect side.
package io_thread_request_queue_pkg;
    typedef struct packed {
        logic        is_store;
        logic [31:0] address;
        logic [31:0] value;
        logic [7:0]  thread_idx;
    } ioreq_packet_t;
    typedef struct packed {
        logic [7:0]  core;
        logic [7:0]  thread_idx;
        logic [31:0] read_value;
    } iorsp_packet_t;
endpackage

interface io_thread_request_queue_if;
    import io_thread_request_queue_pkg::*;
    logic          ior_request_valid;
    ioreq_packet_t ior_request;
    logic          ii_ready;
    logic          ii_response_valid;
    iorsp_packet_t ii_response;
    modport master(output ior_request_valid, ior_request, input ii_ready, ii_response_valid, ii_response);
    modport slave(input ior_request_valid, ior_request, output ii_ready, ii_response_valid, ii_response);
endinterface

// File: rtl/io_thread_request_queue.sv
// io_thread_request_queue: one outstanding IO access per thread, round-robin issue to the interconnect,
// response capture with wake pulse, and completion on replay.
module io_thread_request_queue
    import io_thread_request_queue_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int THREADS_PER_CORE = 4,
    localparam int TW = $clog2(THREADS_PER_CORE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dd_io_write_en,
    input  logic                        dd_io_read_en,
    input  logic [TW-1:0]               dd_io_thread_idx,
    input  logic [31:0]                 dd_io_addr,
    input  logic [31:0]                 dd_io_store_data,
    output logic                        ior_access_complete,
    output logic                        ior_rollback_en,
    output logic [31:0]                 ior_read_value,
    output logic [THREADS_PER_CORE-1:0] ior_pending,
    output logic [THREADS_PER_CORE-1:0] ior_wake_bitmap,
    io_thread_request_queue_if.master   ii
);
    typedef enum logic [1:0] {IDLE, PENDING, ISSUED, DONE} slot_state_t;
    slot_state_t state [THREADS_PER_CORE];
    logic        is_store [THREADS_PER_CORE];
    logic [31:0] addr [THREADS_PER_CORE];
    logic [31:0] value [THREADS_PER_CORE];
    logic [TW-1:0] rr_ptr, held_idx, pick, sel, rsp_idx;
    logic held, found, access, rsp_hit;
    always_comb begin
        pick = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < THREADS_PER_CORE; i++) begin
            if (!found && state[rr_ptr + TW'(i)] == PENDING) begin
                pick = rr_ptr + TW'(i);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        ior_pending = '0;
        for (int i = 0; i < THREADS_PER_CORE; i++)
            ior_pending[i] = state[i] == PENDING || state[i] == ISSUED;
    end
    // a presented request stays locked to its slot until the interconnect grants it
    assign sel = held ? held_idx : pick;
    assign access = dd_io_write_en | dd_io_read_en;
    assign rsp_idx = ii.ii_response.thread_idx[TW-1:0];
    assign rsp_hit = ii.ii_response_valid && ii.ii_response.core == 8'(CORE_ID)
                     && {1'b0, ii.ii_response.thread_idx} < 9'(THREADS_PER_CORE) && state[rsp_idx] == ISSUED;
    assign ii.ior_request_valid = found;
    assign ii.ior_request = '{is_store[sel], addr[sel], value[sel], 8'(sel)};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < THREADS_PER_CORE; i++) begin
                state[i] <= IDLE;
                is_store[i] <= 1'b0;
                addr[i] <= '0;
                value[i] <= '0;
            end
            rr_ptr <= '0;
            held <= 1'b0;
            held_idx <= '0;
            ior_access_complete <= 1'b0;
            ior_rollback_en <= 1'b0;
            ior_read_value <= '0;
            ior_wake_bitmap <= '0;
        end else begin
            ior_access_complete <= access && state[dd_io_thread_idx] == DONE;
            ior_rollback_en <= access && state[dd_io_thread_idx] != DONE;
            ior_wake_bitmap <= rsp_hit ? THREADS_PER_CORE'(1) << rsp_idx : '0;
            held <= found && !ii.ii_ready;
            held_idx <= sel;
            if (access && state[dd_io_thread_idx] == IDLE) begin
                state[dd_io_thread_idx] <= PENDING;
                is_store[dd_io_thread_idx] <= dd_io_write_en;
                addr[dd_io_thread_idx] <= dd_io_addr;
                value[dd_io_thread_idx] <= dd_io_store_data;
            end
            if (access && state[dd_io_thread_idx] == DONE) begin
                state[dd_io_thread_idx] <= IDLE;
                ior_read_value <= is_store[dd_io_thread_idx] ? '0 : value[dd_io_thread_idx];
            end
            if (found && ii.ii_ready) begin
                state[sel] <= ISSUED;
                rr_ptr <= sel + 1'b1;
            end
            // the store data is no longer needed once issued, so the slot reuses it for the response
            if (rsp_hit) begin
                state[rsp_idx] <= DONE;
                value[rsp_idx] <= ii.ii_response.read_value;
            end
        end
    end
endmodule

// File: tb/tb_io_thread_request_queue.sv
// tb_io_thread_request_queue: directed stimulus against a per-thread slot model, checked every cycle,
// plus hand-computed literal expectations.
module tb_io_thread_request_queue;
    import io_thread_request_queue_pkg::*;
    localparam int T = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic we = 1'b0, re = 1'b0;
    logic [1:0] tidx = '0;
    logic [31:0] addr = '0, data = '0;
    logic complete, rollback;
    logic [31:0] rval;
    logic [T-1:0] pend, wake;
    io_thread_request_queue_if ii();
    io_thread_request_queue #(.CORE_ID(0), .THREADS_PER_CORE(T)) dut (
        .clk(clk), .reset(reset), .dd_io_write_en(we), .dd_io_read_en(re), .dd_io_thread_idx(tidx),
        .dd_io_addr(addr), .dd_io_store_data(data), .ior_access_complete(complete), .ior_rollback_en(rollback),
        .ior_read_value(rval), .ior_pending(pend), .ior_wake_bitmap(wake), .ii(ii)
    );
    always #5 clk = ~clk;

    // slot model: 0 idle, 1 waiting for grant, 2 at interconnect, 3 response held
    int ms[T];
    bit mst[T];
    logic [31:0] maddr[T], mdata[T], mresp[T];
    int mptr, mheld_idx;
    bit mheld, e_comp, e_roll;
    logic [31:0] e_rv;
    logic [T-1:0] e_wake;
    int vectors = 0, errs = 0;
    int glog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msel();
        if (mheld) return mheld_idx;
        for (int i = 0; i < T; i++)
            if (ms[(mptr + i) % T] == 1) return (mptr + i) % T;
        return -1;
    endfunction

    task automatic model_update();
        int old[T];
        int s, t, ri;
        old = ms;
        s = msel();
        t = int'(tidx);
        ri = int'(ii.ii_response.thread_idx);
        e_wake = '0;
        e_comp = 1'b0;
        e_roll = 1'b0;
        if (reset) begin
            for (int i = 0; i < T; i++) ms[i] = 0;
            mptr = 0;
            mheld = 1'b0;
            e_rv = '0;
            return;
        end
        if (we || re) begin
            if (old[t] == 0) begin
                ms[t] = 1; mst[t] = we; maddr[t] = addr; mdata[t] = data; e_roll = 1'b1;
            end else if (old[t] == 3) begin
                ms[t] = 0; e_comp = 1'b1; e_rv = mst[t] ? 32'h0 : mresp[t];
            end else e_roll = 1'b1;
        end
        if (s >= 0 && ii.ii_ready) begin
            ms[s] = 2;
            mptr = (s + 1) % T;
        end
        mheld = s >= 0 && !ii.ii_ready;
        mheld_idx = s;
        if (ii.ii_response_valid && ii.ii_response.core == 8'd0 && ri < T && old[ri] == 2) begin
            ms[ri] = 3;
            mresp[ri] = ii.ii_response.read_value;
            e_wake[ri] = 1'b1;
        end
    endtask

    task automatic check();
        logic [T-1:0] ep;
        int s;
        ep = '0;
        for (int i = 0; i < T; i++) ep[i] = ms[i] == 1 || ms[i] == 2;
        s = msel();
        chk("complete", complete, e_comp);
        chk("rollback", rollback, e_roll);
        chk("read_value", rval, e_rv);
        chk("pending", pend, ep);
        chk("wake", wake, e_wake);
        chk("req_valid", ii.ior_request_valid, s >= 0);
        if (s >= 0) begin
            chk("req_is_store", ii.ior_request.is_store, mst[s]);
            chk("req_address", ii.ior_request.address, maddr[s]);
            chk("req_value", ii.ior_request.value, mdata[s]);
            chk("req_thread", ii.ior_request.thread_idx, s);
        end
    endtask

    task automatic step();
        #1;
        if (ii.ior_request_valid && ii.ii_ready) glog.push_back(int'(ii.ior_request.thread_idx));
        model_update();
        @(posedge clk);
        @(negedge clk);
        check();
        we = 1'b0;
        re = 1'b0;
        ii.ii_response_valid = 1'b0;
    endtask

    task automatic acc(input bit w, input bit r, input int t, input logic [31:0] a, input logic [31:0] d);
        we = w; re = r; tidx = 2'(t); addr = a; data = d;
    endtask

    task automatic rsp(input int c, input int t, input logic [31:0] v);
        ii.ii_response_valid = 1'b1;
        ii.ii_response = '{8'(c), 8'(t), v};
    endtask

    initial begin
        ii.ii_ready = 1'b0;
        ii.ii_response_valid = 1'b0;
        ii.ii_response = '0;
        step(); step();
        chk("rst_pend", pend, 0);
        chk("rst_valid", ii.ior_request_valid, 0);
        reset = 1'b0;
        step();
        // fairness: 0, 2, 3 queued while the interconnect stalls
        acc(0, 1, 0, 32'h100, 0); step();
        acc(0, 1, 2, 32'h200, 0); step();
        acc(0, 1, 3, 32'h300, 0); step();
        acc(0, 1, 0, 32'h104, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_thread", ii.ior_request.thread_idx, 0);
            chk("hold_addr", ii.ior_request.address, 32'h100);
        end
        ii.ii_ready = 1'b1;
        step(); step(); step();
        ii.ii_ready = 1'b0;
        chk("grant_count", glog.size(), 3);
        chk("grant0", glog[0], 0);
        chk("grant1", glog[1], 2);
        chk("grant2", glog[2], 3);
        chk("all_issued", pend, 4'b1101);
        rsp(0, 0, 32'hAAAA0000); step();
        chk("wake_t0", wake, 4'b0001);
        rsp(0, 3, 32'h33333333); step();
        // collision: response and re-access of thread 2 together
        rsp(0, 2, 32'h22222222); acc(0, 1, 2, 32'h200, 0); step();
        chk("coll_roll", rollback, 1);
        chk("coll_wake", wake, 4'b0100);
        acc(0, 1, 2, 32'h200, 0); step();
        chk("coll_done", complete, 1);
        chk("coll_val", rval, 32'h22222222);
        acc(0, 1, 0, 32'h100, 0); step();
        chk("t0_val", rval, 32'hAAAA0000);
        acc(0, 1, 3, 32'h300, 0); step();
        // single load
        acc(0, 1, 1, 32'h40, 0); step();
        chk("ld_roll", rollback, 1);
        chk("ld_pend", pend, 4'b0010);
        chk("ld_addr", ii.ior_request.address, 32'h40);
        chk("ld_thread", ii.ior_request.thread_idx, 1);
        chk("ld_is_store", ii.ior_request.is_store, 0);
        step(); step();
        ii.ii_ready = 1'b1; step(); ii.ii_ready = 1'b0;
        step();
        rsp(0, 1, 32'hDEADBEEF); step();
        chk("ld_wake", wake, 4'b0010);
        step();
        chk("ld_wake_off", wake, 0);
        acc(0, 1, 1, 32'h40, 0); step();
        chk("ld_done", complete, 1);
        chk("ld_val", rval, 32'hDEADBEEF);
        chk("ld_pend_clr", pend, 0);
        // store
        acc(1, 0, 0, 32'h80, 32'h1234); step();
        chk("st_is_store", ii.ior_request.is_store, 1);
        chk("st_value", ii.ior_request.value, 32'h1234);
        ii.ii_ready = 1'b1; step(); ii.ii_ready = 1'b0;
        step();
        rsp(0, 0, 32'h5555); step();
        acc(1, 0, 0, 32'h80, 32'h1234); step();
        chk("st_done", complete, 1);
        chk("st_val", rval, 0);
        // write and read together behave as a store
        acc(1, 1, 2, 32'h90, 32'h77); step();
        chk("both_is_store", ii.ior_request.is_store, 1);
        ii.ii_ready = 1'b1; step(); ii.ii_ready = 1'b0;
        rsp(0, 2, 32'h99); step();
        acc(0, 1, 2, 32'h90, 0); step();
        chk("both_val", rval, 0);
        // foreign and stale responses
        acc(0, 1, 1, 32'h44, 0); step();
        ii.ii_ready = 1'b1; step(); ii.ii_ready = 1'b0;
        rsp(1, 1, 32'h1111); step();
        chk("foreign_wake", wake, 0);
        chk("foreign_pend", pend, 4'b0010);
        rsp(0, 0, 32'h2222); step();
        chk("stale_wake", wake, 0);
        rsp(0, 1, 32'hCAFE); step();
        chk("real_wake", wake, 4'b0010);
        acc(0, 1, 1, 32'h44, 0); step();
        chk("real_val", rval, 32'hCAFE);
        // reset while thread 3 is at the interconnect
        acc(0, 1, 3, 32'h300, 0); step();
        ii.ii_ready = 1'b1; step(); ii.ii_ready = 1'b0;
        reset = 1'b1; step();
        chk("mrst_complete", complete, 0);
        chk("mrst_roll", rollback, 0);
        chk("mrst_val", rval, 0);
        chk("mrst_pend", pend, 0);
        chk("mrst_valid", ii.ior_request_valid, 0);
        reset = 1'b0;
        rsp(0, 3, 32'hBAD); step();
        chk("post_rst_wake", wake, 0);
        chk("post_rst_pend", pend, 0);
        acc(0, 1, 3, 32'h304, 0); step();
        chk("realloc_roll", rollback, 1);
        chk("realloc_pend", pend, 4'b1000);
        chk("realloc_addr", ii.ior_request.address, 32'h304);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
